// File: rtl/bp_be_prefetch_stream_engine_pkg.sv
// bp_be_prefetch_stream_engine_pkg
// Shared definitions for the multi-stream backend prefetch engine:
//   - bp_be_pf_stream_state_e : per-slot state (idle / delay / walk / send)
//   - bp_be_pf_gate_state_e   : dispatch gate state (ready / wait commit / wait miss)
//   - bp_be_decode_s          : backend decode bundle driven alongside the prefetch op
//   - PrefetchRInstr          : fixed prefetch.r encoding (OP-IMM, funct3 110, rs2 00001)
//   - PrefetchDecode          : load-like decode with prefetch set and no writeback/scoreboard
// Optional feature macro (consumed by the top): BP_BE_PREFETCH_SIGNED_STRIDE_EN.
package bp_be_prefetch_stream_engine_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StWalk,
        StSend
    } bp_be_pf_stream_state_e;

    typedef enum logic [1:0] {
        StReady,
        StWaitCommit,
        StWaitMiss
    } bp_be_pf_gate_state_e;

    typedef struct packed {
        logic       irf_w_v;
        logic       score_v;
        logic       pipe_mem_v;
        logic       mem_v;
        logic       dcache_r_v;
        logic       prefetch;
        logic [3:0] fu_op;
    } bp_be_decode_s;

    localparam logic [3:0] DcacheOpLd = 4'h3;

    // imm[4:0]=00001 (rs2 slot), rs1=x0, funct3=110, rd=x0, opcode=OP-IMM
    localparam logic [31:0] PrefetchRInstr = 32'h0010_6013;

    localparam bp_be_decode_s PrefetchDecode = '{
        irf_w_v    : 1'b0,
        score_v    : 1'b0,
        pipe_mem_v : 1'b1,
        mem_v      : 1'b1,
        dcache_r_v : 1'b1,
        prefetch   : 1'b1,
        fu_op      : DcacheOpLd
    };

endpackage

// File: rtl/bp_be_prefetch_stream_slot.sv
// bp_be_prefetch_stream_slot
// One strided-load stream: holds tag, address, stride, remaining count, start delay and stale
// budget, walks the address one stride per cycle and raises a request whenever the walk
// crosses into a new D$ block.
// Ports:
//   clk_i, reset_i   : clock, synchronous active-high reset
//   train_i          : load a new stream (wins over every other event this cycle)
//   train_tag_i      : load PC used as the stream tag
//   train_addr_i     : base address
//   train_stride_i   : stride, already extended to vaddr width
//   train_count_i    : number of strides to walk (nonzero)
//   commit_hit_i     : a committed instruction matched this slot's tag
//   grant_i          : this slot's prefetch was consumed by dispatch
//   idle_o           : slot is free
//   req_o            : slot holds a pending prefetch
//   tag_o, addr_o    : stream tag and current (pending while requesting) address
module bp_be_prefetch_stream_slot
    import bp_be_prefetch_stream_engine_pkg::*;
#(
    parameter int unsigned vaddr_width_p        = 39,
    parameter int unsigned loop_range_p         = 8,
    parameter int unsigned block_offset_width_p = 6,
    parameter int unsigned delay_iters_p        = 2,
    parameter int unsigned stale_limit_p        = 15
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     train_i,
    input  logic [vaddr_width_p-1:0] train_tag_i,
    input  logic [vaddr_width_p-1:0] train_addr_i,
    input  logic [vaddr_width_p-1:0] train_stride_i,
    input  logic [loop_range_p-1:0]  train_count_i,
    input  logic                     commit_hit_i,
    input  logic                     grant_i,
    output logic                     idle_o,
    output logic                     req_o,
    output logic [vaddr_width_p-1:0] tag_o,
    output logic [vaddr_width_p-1:0] addr_o
);

    localparam int unsigned DelayW = (delay_iters_p > 0) ? $clog2(delay_iters_p + 1) : 1;
    localparam int unsigned StaleW = (stale_limit_p > 0) ? $clog2(stale_limit_p + 1) : 1;

    bp_be_pf_stream_state_e r_state, w_state_n;

    logic [vaddr_width_p-1:0] r_tag, r_addr, r_stride;
    logic [loop_range_p-1:0]  r_count;
    logic [DelayW-1:0]        r_delay;
    logic [StaleW-1:0]        r_stale;

    logic [vaddr_width_p-1:0] w_next_addr;
    logic [loop_range_p-1:0]  w_next_count;
    logic                     w_cross;
    logic                     w_drop;

    assign w_next_addr  = r_addr + r_stride;
    assign w_next_count = r_count - loop_range_p'(1);
    assign w_cross      = w_next_addr[vaddr_width_p-1:block_offset_width_p]
                       != r_addr[vaddr_width_p-1:block_offset_width_p];
    // The matching commit that would take the budget to zero drops the prefetch.
    assign w_drop       = commit_hit_i && (r_stale <= StaleW'(1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        if (train_i) begin
            w_state_n = StDelay;
        end else begin
            unique case (r_state)
                StIdle:  w_state_n = StIdle;
                StDelay: if (r_delay <= DelayW'(1)) w_state_n = StWalk;
                StWalk: begin
                    if (w_cross)                               w_state_n = StSend;
                    else if (w_next_count == '0)               w_state_n = StIdle;
                end
                // A grant and a stale drop share the same exit rule.
                StSend: begin
                    if (grant_i || w_drop) w_state_n = (r_count != '0) ? StWalk : StIdle;
                end
                default: w_state_n = StIdle;
            endcase
        end
    end

    always_comb begin
        idle_o = (r_state == StIdle);
        req_o  = (r_state == StSend);
        tag_o  = r_tag;
        addr_o = r_addr;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_tag    <= '0;
            r_addr   <= '0;
            r_stride <= '0;
            r_count  <= '0;
            r_delay  <= '0;
            r_stale  <= '0;
        end else if (train_i) begin
            r_tag    <= train_tag_i;
            r_addr   <= train_addr_i;
            r_stride <= train_stride_i;
            r_count  <= train_count_i;
            r_delay  <= DelayW'(delay_iters_p);
            r_stale  <= StaleW'(stale_limit_p);
        end else begin
            unique case (r_state)
                StDelay: if (r_delay != '0) r_delay <= r_delay - DelayW'(1);
                StWalk: begin
                    r_addr  <= w_next_addr;
                    r_count <= w_next_count;
                    // Each new pending prefetch gets a fresh commit budget.
                    if (w_cross) r_stale <= StaleW'(stale_limit_p);
                end
                StSend: if (commit_hit_i && r_stale != '0) r_stale <= r_stale - StaleW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bp_be_prefetch_stream_engine.sv
// bp_be_prefetch_stream_engine
// Tracks up to streams_p strided-load streams, walks each to the next D$ block boundary and
// round-robin arbitrates ready prefetches into a single prefetch.r dispatch slot. At most one
// prefetch is outstanding: after dispatch the gate waits for its commit and for the D$ to
// leave miss processing.
// Ports:
//   clk_i, reset_i                 : clock, synchronous active-high reset
//   v_i / ready_and_o              : training handshake
//   pc_i, eff_addr_i, stride_i     : stream tag, base address, stride
//   loop_counter_i                 : strides to prefetch
//   commit_v_i, commit_pc_i        : committed instruction (drives stale drop)
//   v_o / yumi_i                   : prefetch dispatch handshake
//   instr_o, decode_o, eff_addr_o  : prefetch op, its decode and its address
//   dcache_processing_miss_i       : D$ busy with a miss
//   pfetch_commit_v_i              : outstanding prefetch reached commit
// Macro BP_BE_PREFETCH_SIGNED_STRIDE_EN: sign-extend stride (descending streams); otherwise
// the stride is zero-extended.
module bp_be_prefetch_stream_engine
    import bp_be_prefetch_stream_engine_pkg::*;
#(
    parameter int unsigned vaddr_width_p        = 39,
    parameter int unsigned dcache_block_width_p = 512,
    parameter int unsigned streams_p            = 4,
    parameter int unsigned loop_range_p         = 8,
    parameter int unsigned stride_width_p       = 12,
    parameter int unsigned delay_iters_p        = 2,
    parameter int unsigned stale_limit_p        = 15
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               v_i,
    output logic                               ready_and_o,
    input  logic [vaddr_width_p-1:0]           pc_i,
    input  logic [vaddr_width_p-1:0]           eff_addr_i,
    input  logic [stride_width_p-1:0]          stride_i,
    input  logic [loop_range_p-1:0]            loop_counter_i,
    input  logic                               commit_v_i,
    input  logic [vaddr_width_p-1:0]           commit_pc_i,
    output logic                               v_o,
    input  logic                               yumi_i,
    output logic [31:0]                        instr_o,
    output logic [$bits(bp_be_decode_s)-1:0]   decode_o,
    output logic [vaddr_width_p-1:0]           eff_addr_o,
    input  logic                               dcache_processing_miss_i,
    input  logic                               pfetch_commit_v_i
);

    localparam int unsigned BlockOffW = $clog2(dcache_block_width_p / 8);
    localparam int unsigned PtrW      = (streams_p > 1) ? $clog2(streams_p) : 1;

    logic [streams_p-1:0]     w_idle, w_req_raw, w_req, w_tag_hit, w_commit_hit;
    logic [streams_p-1:0]     w_alloc, w_train, w_grant;
    logic [vaddr_width_p-1:0] w_tag  [streams_p];
    logic [vaddr_width_p-1:0] w_addr [streams_p];
    logic [vaddr_width_p-1:0] w_stride_ext;
    logic                     w_alloc_found, w_any_hit, w_accept, w_any_req, w_dispatch;

    logic [PtrW-1:0]          r_rr_ptr, w_rr_sel, w_sel, r_hold_idx;
    logic [PtrW:0]            w_rr_cand;
    logic                     w_rr_found, r_hold_v;

    bp_be_pf_gate_state_e     r_gate, w_gate_n;
    logic                     w_gate_ready;

`ifdef BP_BE_PREFETCH_SIGNED_STRIDE_EN
    assign w_stride_ext = {{(vaddr_width_p - stride_width_p){stride_i[stride_width_p-1]}},
                           stride_i};
`else
    assign w_stride_ext = {{(vaddr_width_p - stride_width_p){1'b0}}, stride_i};
`endif

    // ---------------- Training / allocation ----------------
    always_comb begin
        w_alloc       = '0;
        w_alloc_found = 1'b0;
        for (int unsigned i = 0; i < streams_p; i++) begin
            w_tag_hit[i]    = ~w_idle[i] && (w_tag[i] == pc_i);
            w_commit_hit[i] = commit_v_i && ~w_idle[i] && (w_tag[i] == commit_pc_i);
            if (!w_alloc_found && w_idle[i]) begin
                w_alloc[i]    = 1'b1;
                w_alloc_found = 1'b1;
            end
        end
    end

    assign w_any_hit   = |w_tag_hit;
    assign ready_and_o = (|w_idle) | w_any_hit;
    // Zero-length or zero-stride requests are handshaken but change nothing.
    assign w_accept    = v_i && ready_and_o && (stride_i != '0) && (loop_counter_i != '0);
    assign w_train     = w_accept ? (w_any_hit ? w_tag_hit : w_alloc) : '0;

    for (genvar g = 0; g < streams_p; g++) begin : gen_slot
        bp_be_prefetch_stream_slot #(
            .vaddr_width_p        (vaddr_width_p),
            .loop_range_p         (loop_range_p),
            .block_offset_width_p (BlockOffW),
            .delay_iters_p        (delay_iters_p),
            .stale_limit_p        (stale_limit_p)
        ) u_slot (
            .clk_i          (clk_i),
            .reset_i        (reset_i),
            .train_i        (w_train[g]),
            .train_tag_i    (pc_i),
            .train_addr_i   (eff_addr_i),
            .train_stride_i (w_stride_ext),
            .train_count_i  (loop_counter_i),
            .commit_hit_i   (w_commit_hit[g]),
            .grant_i        (w_grant[g]),
            .idle_o         (w_idle[g]),
            .req_o          (w_req_raw[g]),
            .tag_o          (w_tag[g]),
            .addr_o         (w_addr[g])
        );

        assign w_grant[g] = w_dispatch && (w_sel == PtrW'(g));
    end

    // ---------------- Round-robin arbitration ----------------
    // A slot being re-trained this cycle must not be offered to dispatch.
    assign w_req     = w_req_raw & ~w_train;
    assign w_any_req = |w_req;

    always_comb begin
        w_rr_sel   = r_rr_ptr;
        w_rr_found = 1'b0;
        w_rr_cand  = '0;
        for (int unsigned i = 0; i < streams_p; i++) begin
            w_rr_cand = {1'b0, r_rr_ptr} + (PtrW + 1)'(i);
            if (w_rr_cand >= (PtrW + 1)'(streams_p)) w_rr_cand = w_rr_cand - (PtrW + 1)'(streams_p);
            if (!w_rr_found && w_req[w_rr_cand[PtrW-1:0]]) begin
                w_rr_sel   = w_rr_cand[PtrW-1:0];
                w_rr_found = 1'b1;
            end
        end
    end

    // Keep offering the same slot while dispatch stalls so eff_addr_o stays stable.
    assign w_sel      = (r_hold_v && w_req[r_hold_idx]) ? r_hold_idx : w_rr_sel;
    assign v_o        = w_gate_ready && ~dcache_processing_miss_i && w_any_req;
    assign w_dispatch = v_o && yumi_i;
    assign eff_addr_o = w_any_req ? w_addr[w_sel] : '0;
    assign instr_o    = PrefetchRInstr;
    assign decode_o   = PrefetchDecode;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr_ptr   <= '0;
            r_hold_v   <= 1'b0;
            r_hold_idx <= '0;
        end else begin
            r_hold_v   <= v_o && ~yumi_i;
            r_hold_idx <= w_sel;
            if (w_dispatch) begin
                r_rr_ptr <= (w_sel == PtrW'(streams_p - 1)) ? '0 : w_sel + PtrW'(1);
            end
        end
    end

    // ---------------- Dispatch gate ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_gate <= StReady;
        end else begin
            r_gate <= w_gate_n;
        end
    end

    always_comb begin
        w_gate_n = r_gate;
        unique case (r_gate)
            StReady:      if (w_dispatch)                w_gate_n = StWaitCommit;
            StWaitCommit: if (pfetch_commit_v_i)         w_gate_n = StWaitMiss;
            StWaitMiss:   if (!dcache_processing_miss_i) w_gate_n = StReady;
            default:                                     w_gate_n = StReady;
        endcase
    end

    always_comb begin
        w_gate_ready = (r_gate == StReady);
    end

endmodule
